m_video_capture: RTL and testbench
==================================

M_VIDEO_CAPTURE -- requirements
Module: m_video_capture

Interface
REQ-001 Parameter PIX_DIV, default 4, sets FCLK cycles per pixel sample.
REQ-002 Parameter H_START, default 40, sets pixel ticks skipped after the HSyncL fall before the first active pixel.
REQ-003 Parameter H_ACTIVE, default 256, sets active pixels per line.
REQ-004 Parameter V_START, default 16, sets lines skipped after the VSyncL fall.
REQ-005 Parameter V_ACTIVE, default 200, sets active lines per frame.
REQ-006 FCLK  in  1  sole clock; every register is on its rising edge.
REQ-007 RESET  in  1  reset, asynchronous and active-high.
REQ-008 HSyncL  in  1  horizontal sync, active low.
REQ-009 VSyncL  in  1  vertical sync, active low.
REQ-010 Blanking  in  1  video blanking flag.
REQ-011 Red, Green, Blue  in  4 each  pixel colour.
REQ-012 pix_valid  out  1  FIFO head entry valid.
REQ-013 pix_ready  in  1  consumer accepts the head entry.
REQ-014 pix_x  out  9  head entry column, 0..H_ACTIVE-1.
REQ-015 pix_y  out  8  head entry row, 0..V_ACTIVE-1.
REQ-016 pix_rgb  out  12  head entry colour, {R,G,B}.
REQ-017 frame_done  out  1  one-cycle pulse marking a completed frame.
REQ-018 overflow  out  1  sticky flag for a dropped pixel.
REQ-019 resync  out  1  sticky flag for a VSyncL fall that arrived mid-frame.

Function
REQ-020 The block registers HSyncL and VSyncL once; a fall is detected when the registered value is 1 and the current input is 0, giving 1 cycle of detection latency.
REQ-021 The pixel tick divider counts 0..PIX_DIV-1 and is cleared on every HSyncL fall; a tick occurs when it equals PIX_DIV-1.
REQ-022 The block has four states: FRAME_WAIT, LINE_WAIT, SKIP and ACTIVE.
REQ-023 FRAME_WAIT: on a VSyncL fall, go to LINE_WAIT with line_cnt=0; ignore HSyncL.
REQ-024 LINE_WAIT on an HSyncL fall:
- If V_START <= line_cnt < V_START+V_ACTIVE: go to SKIP with skip_cnt=0.
- In every case, line_cnt increments by 1.
REQ-025 LINE_WAIT when line_cnt == V_START+V_ACTIVE: pulse frame_done for one cycle and go to FRAME_WAIT.
REQ-026 SKIP: skip_cnt increments on each tick; on the tick where skip_cnt reaches H_START-1, go to ACTIVE with x=0.
REQ-027 ACTIVE, on each tick:
- push {x, line_cnt-1-V_START, rgb} into the FIFO;
- x increments;
- on the tick with x == H_ACTIVE-1, go to LINE_WAIT.
REQ-028 The rgb value captured in REQ-027 is 12'h000 when Blanking=1; otherwise it is {Red,Green,Blue} sampled on the tick cycle.
REQ-029 An HSyncL fall in SKIP or ACTIVE truncates the line: no further pushes occur, and the fall is handled as in LINE_WAIT in the same cycle.
REQ-030 A VSyncL fall in LINE_WAIT, SKIP or ACTIVE sets resync, goes to LINE_WAIT with line_cnt=0, and does not pulse frame_done.
REQ-031 If VSyncL and HSyncL fall in the same cycle, the VSyncL handling wins and the HSyncL fall is ignored.
REQ-032 The FIFO has 16 entries of 29 bits each, is first-in first-out, and has 1-cycle write-to-valid latency.
REQ-033 A pop occurs when pix_valid && pix_ready; the pix_* outputs change only after a pop or a push into an empty FIFO.
REQ-034 A push into a full FIFO is accepted only if a pop happens in the same cycle; otherwise the entry is dropped and overflow is set.
REQ-035 pix_valid=1 exactly when the FIFO count is nonzero, and the count never exceeds 16.
REQ-036 The block never re-orders or duplicates entries.

Reset
REQ-037 RESET=1 immediately sets state=FRAME_WAIT and clears every counter and the FIFO.
REQ-038 During reset: pix_valid=0, pix_x=0, pix_y=0, pix_rgb=0, frame_done=0, overflow=0, resync=0; the registered syncs are 1.
REQ-039 RESET asserted mid-line discards all buffered pixels, and capture restarts only on the next VSyncL fall.

Verification
REQ-040 Default parameters, pix_ready=1, a full frame with rgb=12'hABC -> exactly 51200 entries, x 0..255, y 0..199, all rgb ABC, one frame_done pulse, overflow=0.
REQ-041 pix_ready=0 through one active line -> 16 entries held, 240 dropped, overflow=1, and the head entry is x=0, y=0.
REQ-042 Blanking=1 during the pixels with x=100..109 -> those entries have rgb=12'h000 and their neighbours are unchanged.
REQ-043 VSyncL fall at line_cnt=50 -> resync=1, no frame_done, and the next active entry is y=0.
REQ-044 HSyncL fall while x=128 -> row y has 128 entries and row y+1 starts at x=0.
REQ-045 RESET pulsed while the FIFO holds 10 entries -> pix_valid=0 next cycle, and HSyncL falls are ignored until a VSyncL fall.

Source files
------------

// File: rtl/m_video_capture.sv
// m_video_capture
//   Captures pixels from a sync-framed video source into a 16-entry FIFO.
//   Each HSyncL/VSyncL fall is detected against a one-cycle-delayed copy.
//   A PIX_DIV divider makes a pixel tick. A four-state FSM counts lines and
//   pixels and pushes {x, y, rgb} for every active pixel.
// Ports
//   FCLK, RESET            : clock, asynchronous active-high reset
//   HSyncL, VSyncL         : active-low syncs
//   Blanking               : forces captured colour to 0
//   Red, Green, Blue       : 4-bit colour components
//   pix_valid/pix_ready    : FIFO head handshake
//   pix_x, pix_y, pix_rgb  : FIFO head entry
//   frame_done             : one-cycle pulse at the end of a complete frame
//   overflow, resync       : sticky error flags
module m_video_capture #(
  parameter int PIX_DIV  = 4,
  parameter int H_START  = 40,
  parameter int H_ACTIVE = 256,
  parameter int V_START  = 16,
  parameter int V_ACTIVE = 200
) (
  input  logic        FCLK,
  input  logic        RESET,
  input  logic        HSyncL,
  input  logic        VSyncL,
  input  logic        Blanking,
  input  logic [3:0]  Red,
  input  logic [3:0]  Green,
  input  logic [3:0]  Blue,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [8:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_done,
  output logic        overflow,
  output logic        resync
);

  localparam int V_END = V_START + V_ACTIVE;
  localparam int LCW   = $clog2(V_END + 1);
  localparam int SW    = (H_START > 1) ? $clog2(H_START) : 1;
  localparam int DVW   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  typedef enum logic [1:0] {S_FRAME_WAIT, S_LINE_WAIT, S_SKIP, S_ACTIVE} state_t;

  state_t           r_state;
  logic             r_hs_q, r_vs_q;
  logic [DVW-1:0]   r_div;
  logic [LCW-1:0]   r_line;
  logic [SW-1:0]    r_skip;
  logic [8:0]       r_x;

  logic [28:0]      r_mem [16];
  logic [3:0]       r_wp, r_rp;
  logic [4:0]       r_cnt;

  logic             w_hs_fall, w_vs_fall, w_tick, w_line_evt, w_in_frame;
  logic             w_push, w_pop, w_wr, w_full;
  logic [7:0]       w_y;
  logic [11:0]      w_rgb;

  assign w_hs_fall = r_hs_q & ~HSyncL;
  assign w_vs_fall = r_vs_q & ~VSyncL;
  assign w_tick    = (r_div == DVW'(PIX_DIV - 1));

  // A sync fall during SKIP/ACTIVE truncates the line and is processed
  // exactly like a LINE_WAIT cycle.
  assign w_line_evt = (r_state == S_LINE_WAIT) ||
                      (((r_state == S_SKIP) || (r_state == S_ACTIVE)) && w_hs_fall);
  assign w_in_frame = (r_line >= LCW'(V_START)) && (r_line < LCW'(V_END));

  // r_line was already bumped on the HSyncL fall that opened this line.
  assign w_y   = 8'(r_line - LCW'(V_START + 1));
  assign w_rgb = Blanking ? 12'h000 : {Red, Green, Blue};

  assign w_push = (r_state == S_ACTIVE) && w_tick && !w_hs_fall && !w_vs_fall;

  // Sync edge detect and pixel divider.
  always_ff @(posedge FCLK or posedge RESET) begin
    if (RESET) begin
      r_hs_q <= 1'b1;
      r_vs_q <= 1'b1;
      r_div  <= '0;
    end else begin
      r_hs_q <= HSyncL;
      r_vs_q <= VSyncL;
      if (w_hs_fall || w_tick) r_div <= '0;
      else                     r_div <= r_div + DVW'(1);
    end
  end

  // Frame / line FSM.
  always_ff @(posedge FCLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_FRAME_WAIT;
      r_line     <= '0;
      r_skip     <= '0;
      r_x        <= '0;
      frame_done <= 1'b0;
      resync     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (w_vs_fall) begin
        // VSyncL has priority; a coincident HSyncL fall is dropped.
        if (r_state != S_FRAME_WAIT) resync <= 1'b1;
        r_state <= S_LINE_WAIT;
        r_line  <= '0;
      end else if (w_line_evt) begin
        if (r_line == LCW'(V_END)) begin
          frame_done <= 1'b1;
          r_state    <= S_FRAME_WAIT;
        end else if (w_hs_fall) begin
          r_line <= r_line + LCW'(1);
          if (w_in_frame) begin
            r_state <= S_SKIP;
            r_skip  <= '0;
          end else begin
            r_state <= S_LINE_WAIT;
          end
        end
      end else if (w_tick) begin
        case (r_state)
          S_SKIP: begin
            if (r_skip == SW'(H_START - 1)) begin
              r_state <= S_ACTIVE;
              r_x     <= '0;
            end else begin
              r_skip <= r_skip + SW'(1);
            end
          end
          S_ACTIVE: begin
            r_x <= r_x + 9'd1;
            if (r_x == 9'(H_ACTIVE - 1)) r_state <= S_LINE_WAIT;
          end
          default: ;
        endcase
      end
    end
  end

  // 16-entry FIFO. A full FIFO still takes a push when the head pops in
  // the same cycle, since the freed slot is the one being written.
  assign pix_valid = (r_cnt != 5'd0);
  assign w_pop     = pix_valid & pix_ready;
  assign w_full    = (r_cnt == 5'd16);
  assign w_wr      = w_push & (~w_full | w_pop);
  assign {pix_x, pix_y, pix_rgb} = r_mem[r_rp];

  always_ff @(posedge FCLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= {r_x, w_y, w_rgb};
        r_wp        <= r_wp + 4'd1;
      end
      if (w_pop) r_rp <= r_rp + 4'd1;
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 5'd1;
        2'b01:   r_cnt <= r_cnt - 5'd1;
        default: ;
      endcase
      if (w_push && !w_wr) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_m_video_capture.sv
// Directed bench for m_video_capture with a reduced geometry so whole
// frames fit in a short run: PIX_DIV=4, H_START=4, H_ACTIVE=24,
// V_START=2, V_ACTIVE=6. With these values, the HSyncL fall is seen at
// line cycle 0. Pixel x is then pushed at line cycle 4*x+20, so the
// last pixel (x=23) is pushed at cycle 112.
module tb_m_video_capture;

  localparam int PD = 4, HS = 4, HA = 24, VS = 2, VA = 6;
  localparam int LINE = 120;

  logic        FCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        HSyncL = 1'b1, VSyncL = 1'b1, Blanking = 1'b0;
  logic [3:0]  Red = 4'hA, Green = 4'hB, Blue = 4'hC;
  logic        pix_valid, pix_ready = 1'b1;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic [11:0] pix_rgb;
  logic        frame_done, overflow, resync;

  int checks = 0;
  int errors = 0;

  logic [8:0]  qx[$];
  logic [7:0]  qy[$];
  logic [11:0] qc[$];
  int          n_fd = 0;

  m_video_capture #(.PIX_DIV(PD), .H_START(HS), .H_ACTIVE(HA),
                    .V_START(VS), .V_ACTIVE(VA)) dut (
    .FCLK(FCLK), .RESET(RESET), .HSyncL(HSyncL), .VSyncL(VSyncL),
    .Blanking(Blanking), .Red(Red), .Green(Green), .Blue(Blue),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x),
    .pix_y(pix_y), .pix_rgb(pix_rgb), .frame_done(frame_done),
    .overflow(overflow), .resync(resync)
  );

  always #5 FCLK = ~FCLK;

  // Record every popped entry and every frame_done cycle.
  always @(negedge FCLK) begin
    if (!RESET && pix_valid && pix_ready) begin
      qx.push_back(pix_x);
      qy.push_back(pix_y);
      qc.push_back(pix_rgb);
    end
    if (frame_done) n_fd++;
  end

  task automatic clear_log();
    qx.delete(); qy.delete(); qc.delete(); n_fd = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge FCLK); #1; end
  endtask

  task automatic do_reset();
    RESET = 1'b1; HSyncL = 1'b1; VSyncL = 1'b1; Blanking = 1'b0;
    idle(3);
    RESET = 1'b0;
    idle(2);
    clear_log();
  endtask

  task automatic vsync();
    VSyncL = 1'b0; idle(4);
    VSyncL = 1'b1; idle(10);
  endtask

  // One line: HSyncL low for cycles 0..3, optional coincident VSyncL fall,
  // and Blanking asserted on the tick cycles of pixels blo..bhi.
  task automatic run_line(input int len, input bit vs, input int blo, input int bhi);
    for (int c = 0; c < len; c++) begin
      HSyncL   = (c < 4) ? 1'b0 : 1'b1;
      VSyncL   = (vs && c < 4) ? 1'b0 : 1'b1;
      Blanking = (c % 4 == 0) && (c >= 20) && ((c - 20) / 4 >= blo) && ((c - 20) / 4 <= bhi);
      @(posedge FCLK); #1;
    end
    Blanking = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; idle(2);
    checks++;
    if ({pix_valid, frame_done, overflow, resync} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {pix_valid, frame_done, overflow, resync});
    end
    checks++;
    if ({pix_x, pix_y, pix_rgb} !== 29'd0) begin
      errors++; $display("FAIL reset_head got %h want 0", {pix_x, pix_y, pix_rgb});
    end
    do_reset();
  endtask

  task automatic test_full_frame();
    logic [11:0] er;
    int ex, ey;
    do_reset();
    pix_ready = 1'b1; Red = 4'hA; Green = 4'hB; Blue = 4'hC;
    vsync();
    for (int k = 0; k < VS + VA; k++) run_line(LINE, 1'b0, (k == 3) ? 10 : -1, (k == 3) ? 13 : -1);
    idle(10);
    checks++;
    if (qx.size() !== HA * VA) begin
      errors++; $display("FAIL frame_count got %0d want %0d", qx.size(), HA * VA);
    end
    for (int i = 0; i < qx.size() && i < HA * VA; i++) begin
      ex = i % HA; ey = i / HA;
      er = (ey == 1 && ex >= 10 && ex <= 13) ? 12'h000 : 12'hABC;
      checks++;
      if (qx[i] !== ex[8:0] || qy[i] !== ey[7:0] || qc[i] !== er) begin
        errors++;
        $display("FAIL frame_entry %0d got x=%0d y=%0d rgb=%h want x=%0d y=%0d rgb=%h",
                 i, qx[i], qy[i], qc[i], ex, ey, er);
      end
    end
    checks++;
    if (n_fd !== 1) begin errors++; $display("FAIL frame_done_pulses got %0d want 1", n_fd); end
    checks++;
    if (overflow !== 1'b0 || resync !== 1'b0) begin
      errors++; $display("FAIL frame_flags got ovf=%b rsy=%b want 0 0", overflow, resync);
    end
    // Back in FRAME_WAIT: HSyncL alone must not capture anything.
    clear_log();
    for (int k = 0; k < 3; k++) run_line(LINE, 1'b0, -1, -1);
    checks++;
    if (qx.size() !== 0) begin errors++; $display("FAIL frame_wait_idle got %0d want 0", qx.size()); end
  endtask

  task automatic test_overflow();
    do_reset();
    pix_ready = 1'b0; Red = 4'h5; Green = 4'hA; Blue = 4'h3;
    vsync();
    for (int k = 0; k < 3; k++) run_line(LINE, 1'b0, -1, -1);
    checks++;
    if (pix_valid !== 1'b1 || pix_x !== 9'd0 || pix_y !== 8'd0 || pix_rgb !== 12'h5A3) begin
      errors++; $display("FAIL ovf_head got v=%b x=%0d y=%0d rgb=%h want 1 0 0 5a3", pix_valid, pix_x, pix_y, pix_rgb);
    end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    pix_ready = 1'b1;
    idle(25);
    checks++;
    if (qx.size() !== 16) begin errors++; $display("FAIL ovf_held got %0d want 16", qx.size()); end
    for (int i = 0; i < qx.size() && i < 16; i++) begin
      checks++;
      if (qx[i] !== 9'(i) || qy[i] !== 8'd0) begin
        errors++; $display("FAIL ovf_entry %0d got x=%0d y=%0d want x=%0d y=0", i, qx[i], qy[i], i);
      end
    end
    checks++;
    if (pix_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b want 0", pix_valid); end
  endtask

  task automatic test_resync();
    do_reset();
    pix_ready = 1'b1;
    vsync();
    for (int k = 0; k < 4; k++) run_line(LINE, 1'b0, -1, -1);
    checks++;
    if (qx.size() !== 48 || resync !== 1'b0) begin
      errors++; $display("FAIL resync_pre got n=%0d rsy=%b want 48 0", qx.size(), resync);
    end
    clear_log();
    // VSyncL and HSyncL fall together: VSyncL wins, HSyncL is ignored.
    run_line(LINE, 1'b1, -1, -1);
    checks++;
    if (resync !== 1'b1) begin errors++; $display("FAIL resync_flag got %b want 1", resync); end
    run_line(LINE, 1'b0, -1, -1);
    run_line(LINE, 1'b0, -1, -1);
    checks++;
    if (qx.size() !== 0) begin errors++; $display("FAIL resync_skip got %0d want 0", qx.size()); end
    run_line(LINE, 1'b0, -1, -1);
    checks++;
    if (qx.size() !== 24) begin errors++; $display("FAIL resync_count got %0d want 24", qx.size()); end
    checks++;
    if (qx.size() > 0 && (qx[0] !== 9'd0 || qy[0] !== 8'd0)) begin
      errors++; $display("FAIL resync_first got x=%0d y=%0d want 0 0", qx[0], qy[0]);
    end
    checks++;
    if (n_fd !== 0) begin errors++; $display("FAIL resync_no_done got %0d want 0", n_fd); end
  endtask

  task automatic test_truncate();
    do_reset();
    pix_ready = 1'b1;
    vsync();
    run_line(LINE, 1'b0, -1, -1);
    run_line(LINE, 1'b0, -1, -1);
    run_line(68, 1'b0, -1, -1);   // next fall lands on the tick of x=12
    run_line(LINE, 1'b0, -1, -1);
    checks++;
    if (qx.size() !== 36) begin errors++; $display("FAIL trunc_count got %0d want 36", qx.size()); end
    if (qx.size() >= 13) begin
      checks++;
      if (qx[11] !== 9'd11 || qy[11] !== 8'd0) begin
        errors++; $display("FAIL trunc_last got x=%0d y=%0d want 11 0", qx[11], qy[11]);
      end
      checks++;
      if (qx[12] !== 9'd0 || qy[12] !== 8'd1) begin
        errors++; $display("FAIL trunc_next got x=%0d y=%0d want 0 1", qx[12], qy[12]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pix_ready = 1'b0;
    vsync();
    run_line(LINE, 1'b0, -1, -1);
    run_line(LINE, 1'b0, -1, -1);
    run_line(60, 1'b0, -1, -1);   // pushes x=0..9
    checks++;
    if (pix_valid !== 1'b1 || pix_x !== 9'd0) begin
      errors++; $display("FAIL mid_held got v=%b x=%0d want 1 0", pix_valid, pix_x);
    end
    RESET = 1'b1; idle(1);
    checks++;
    if (pix_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", pix_valid); end
    RESET = 1'b0; pix_ready = 1'b1;
    idle(2); clear_log();
    for (int k = 0; k < 4; k++) run_line(LINE, 1'b0, -1, -1);
    checks++;
    if (qx.size() !== 0 || pix_valid !== 1'b0) begin
      errors++; $display("FAIL mid_ignore_hs got n=%0d v=%b want 0 0", qx.size(), pix_valid);
    end
    vsync();
    for (int k = 0; k < 3; k++) run_line(LINE, 1'b0, -1, -1);
    checks++;
    if (qx.size() !== 24) begin errors++; $display("FAIL mid_restart got %0d want 24", qx.size()); end
    checks++;
    if (qx.size() > 0 && (qx[0] !== 9'd0 || qy[0] !== 8'd0)) begin
      errors++; $display("FAIL mid_restart_first got x=%0d y=%0d want 0 0", qx[0], qy[0]);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_overflow();
    test_resync();
    test_truncate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
